// File: rtl/rob_pkg.sv
// rob_pkg: shared constants and types for the reorder buffer / commit stage.
//   DEPTH  - number of ROB entries (power of 2)
//   TAG_W  - entry tag width, log2(DEPTH)
//   REG_W  - architectural register address width
//   DATA_W - result data width
//   NCDB   - number of completion broadcast ports
package rob_pkg;

  localparam int DEPTH  = 16;
  localparam int TAG_W  = 4;
  localparam int REG_W  = 4;
  localparam int DATA_W = 16;
  localparam int NCDB   = 3;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  typedef logic [TAG_W:0]   ptr_t;
  typedef logic [TAG_W-1:0] tag_t;

  typedef struct packed {
    logic              valid;
    logic              done;
    logic              wr;
    logic [REG_W-1:0]  dest;
    logic [DATA_W-1:0] data;
  } rob_entry_t;

endpackage

// File: rtl/rob_cdb_match.sv
// rob_cdb_match: compares all completion broadcast ports against one ROB
// entry index and selects the result to capture.
//   entry_idx - index of the ROB entry this instance serves
//   cdb_valid - per-port broadcast valid
//   cdb_tag   - per-port completing tag
//   cdb_data  - per-port result value
//   hit       - at least one valid port names this entry
//   data      - result from the lowest-numbered matching port
module rob_cdb_match
  import rob_pkg::*;
(
  input  tag_t                         entry_idx,
  input  logic [NCDB-1:0]              cdb_valid,
  input  logic [NCDB-1:0][TAG_W-1:0]   cdb_tag,
  input  logic [NCDB-1:0][DATA_W-1:0]  cdb_data,
  output logic                         hit,
  output logic [DATA_W-1:0]            data
);

  // Scan from the highest port down so the lowest matching port is the
  // last assignment and therefore wins.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    for (int p = NCDB - 1; p >= 0; p--) begin
      if (cdb_valid[p] && (cdb_tag[p] == entry_idx)) begin
        hit  = 1'b1;
        data = cdb_data[p];
      end
    end
  end

endmodule

// File: rtl/rob_commit.sv
// rob_commit: in-order reorder buffer with dual dispatch, three completion
// broadcast ports and dual in-order retirement into the register file.
//   clk, rst_n            - clock and synchronous active-low reset
//   flush                 - discard all entries
//   disp_valid0/1, disp_wr0/1, disp_dest0/1 - dispatch slots (0 older)
//   disp_ready            - at least two free entries (registered count)
//   disp_tag0/1           - tags handed to dispatch slots 0 and 1
//   cdb_valid0..2, cdb_tag0..2, cdb_data0..2 - completion broadcasts
//   wen0/waddr0/wdata0    - registered commit write, older entry
//   wen1/waddr1/wdata1    - registered commit write, younger entry
//   count                 - occupied entries, 0..DEPTH
module rob_commit
  import rob_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              disp_valid0,
  input  logic              disp_wr0,
  input  logic [REG_W-1:0]  disp_dest0,
  input  logic              disp_valid1,
  input  logic              disp_wr1,
  input  logic [REG_W-1:0]  disp_dest1,
  output logic              disp_ready,
  output logic [TAG_W-1:0]  disp_tag0,
  output logic [TAG_W-1:0]  disp_tag1,
  input  logic              cdb_valid0,
  input  logic [TAG_W-1:0]  cdb_tag0,
  input  logic [DATA_W-1:0] cdb_data0,
  input  logic              cdb_valid1,
  input  logic [TAG_W-1:0]  cdb_tag1,
  input  logic [DATA_W-1:0] cdb_data1,
  input  logic              cdb_valid2,
  input  logic [TAG_W-1:0]  cdb_tag2,
  input  logic [DATA_W-1:0] cdb_data2,
  output logic              wen0,
  output logic [REG_W-1:0]  waddr0,
  output logic [DATA_W-1:0] wdata0,
  output logic              wen1,
  output logic [REG_W-1:0]  waddr1,
  output logic [DATA_W-1:0] wdata1,
  output logic [TAG_W:0]    count
);

  rob_entry_t rob_q [DEPTH];
  rob_entry_t rob_d [DEPTH];

  ptr_t head_q, head_d;
  ptr_t tail_q, tail_d;
  ptr_t count_w;

  logic              wen0_q, wen1_q;
  logic [REG_W-1:0]  waddr0_q, waddr1_q;
  logic [DATA_W-1:0] wdata0_q, wdata1_q;

  tag_t head0_idx, head1_idx;
  logic alloc0, alloc1;
  logic c0, c1;

  logic [NCDB-1:0]             cdb_valid_w;
  logic [NCDB-1:0][TAG_W-1:0]  cdb_tag_w;
  logic [NCDB-1:0][DATA_W-1:0] cdb_data_w;
  logic [DEPTH-1:0]            hit_w;
  logic [DATA_W-1:0]           hit_data_w [DEPTH];

  assign cdb_valid_w = {cdb_valid2, cdb_valid1, cdb_valid0};
  assign cdb_tag_w   = {cdb_tag2, cdb_tag1, cdb_tag0};
  assign cdb_data_w  = {cdb_data2, cdb_data1, cdb_data0};

  // Pointer difference is the occupancy; the wrap bit makes 0 and DEPTH distinct.
  assign count_w    = tail_q - head_q;
  assign count      = count_w;
  assign disp_ready = (ptr_t'(DEPTH) - count_w) >= ptr_t'(2);
  assign disp_tag0  = tail_q[TAG_W-1:0];
  assign disp_tag1  = disp_tag0 + tag_t'(1);

  assign alloc0 = disp_valid0 && disp_ready;
  assign alloc1 = alloc0 && disp_valid1;

  assign head0_idx = head_q[TAG_W-1:0];
  assign head1_idx = head0_idx + tag_t'(1);

  // Commit looks only at registered done flags, so a result broadcast this
  // cycle retires no earlier than next cycle.
  assign c0 = rob_q[head0_idx].valid && rob_q[head0_idx].done;
  assign c1 = c0 && rob_q[head1_idx].valid && rob_q[head1_idx].done;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
      rob_cdb_match u_match (
        .entry_idx (tag_t'(gi)),
        .cdb_valid (cdb_valid_w),
        .cdb_tag   (cdb_tag_w),
        .cdb_data  (cdb_data_w),
        .hit       (hit_w[gi]),
        .data      (hit_data_w[gi])
      );
    end
  endgenerate

  // Update order: completion, then commit clear, then allocation. Commit and
  // allocation never touch the same slot (allocation only writes free slots),
  // and completion is gated by the registered valid bit so a slot being
  // allocated this cycle cannot be marked done.
  always_comb begin
    rob_d = rob_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (rob_q[i].valid && hit_w[i]) begin
        rob_d[i].done = 1'b1;
        rob_d[i].data = hit_data_w[i];
      end
    end
    if (c0) rob_d[head0_idx] = '0;
    if (c1) rob_d[head1_idx] = '0;
    if (alloc0) begin
      rob_d[disp_tag0] = '{valid: 1'b1, done: 1'b0, wr: disp_wr0,
                           dest: disp_dest0, data: '0};
    end
    if (alloc1) begin
      rob_d[disp_tag1] = '{valid: 1'b1, done: 1'b0, wr: disp_wr1,
                           dest: disp_dest1, data: '0};
    end
    head_d = head_q + ptr_t'(c0) + ptr_t'(c1);
    tail_d = tail_q + ptr_t'(alloc0) + ptr_t'(alloc1);
  end

  // Flush shares the reset path: everything in flight, including this
  // cycle's would-be commits, is dropped.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      for (int i = 0; i < DEPTH; i++) rob_q[i] <= '0;
      head_q   <= '0;
      tail_q   <= '0;
      wen0_q   <= 1'b0;
      wen1_q   <= 1'b0;
      waddr0_q <= '0;
      waddr1_q <= '0;
      wdata0_q <= '0;
      wdata1_q <= '0;
    end else begin
      rob_q  <= rob_d;
      head_q <= head_d;
      tail_q <= tail_d;
      wen0_q <= c0 && rob_q[head0_idx].wr;
      wen1_q <= c1 && rob_q[head1_idx].wr;
      // Address/data hold their previous value on cycles with no write.
      if (c0 && rob_q[head0_idx].wr) begin
        waddr0_q <= rob_q[head0_idx].dest;
        wdata0_q <= rob_q[head0_idx].data;
      end
      if (c1 && rob_q[head1_idx].wr) begin
        waddr1_q <= rob_q[head1_idx].dest;
        wdata1_q <= rob_q[head1_idx].data;
      end
    end
  end

  assign wen0   = wen0_q;
  assign waddr0 = waddr0_q;
  assign wdata0 = wdata0_q;
  assign wen1   = wen1_q;
  assign waddr1 = waddr1_q;
  assign wdata1 = wdata1_q;

endmodule

// File: tb/tb_rob_commit.sv
// tb_rob_commit: directed scenarios followed by randomized traffic, checked
// every cycle against a queue-based model of the reorder buffer.
module tb_rob_commit;
  import rob_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              flush = 1'b0;
  logic              dv0 = 1'b0, dwr0 = 1'b0, dv1 = 1'b0, dwr1 = 1'b0;
  logic [REG_W-1:0]  dd0 = '0, dd1 = '0;
  logic              cv [3];
  logic [TAG_W-1:0]  ct [3];
  logic [DATA_W-1:0] cd [3];

  logic              disp_ready;
  logic [TAG_W-1:0]  disp_tag0, disp_tag1;
  logic              wen0, wen1;
  logic [REG_W-1:0]  waddr0, waddr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic [TAG_W:0]    count;

  always #5 clk = ~clk;

  rob_commit dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .disp_valid0(dv0), .disp_wr0(dwr0), .disp_dest0(dd0),
    .disp_valid1(dv1), .disp_wr1(dwr1), .disp_dest1(dd1),
    .disp_ready(disp_ready), .disp_tag0(disp_tag0), .disp_tag1(disp_tag1),
    .cdb_valid0(cv[0]), .cdb_tag0(ct[0]), .cdb_data0(cd[0]),
    .cdb_valid1(cv[1]), .cdb_tag1(ct[1]), .cdb_data1(cd[1]),
    .cdb_valid2(cv[2]), .cdb_tag2(ct[2]), .cdb_data2(cd[2]),
    .wen0(wen0), .waddr0(waddr0), .wdata0(wdata0),
    .wen1(wen1), .waddr1(waddr1), .wdata1(wdata1),
    .count(count)
  );

  // Reference model: program-ordered list of in-flight instructions.
  typedef struct {
    int       tag;
    bit       wr;
    bit [3:0] dest;
    bit       done;
    bit [15:0] data;
  } m_ent_t;

  m_ent_t    mq[$];
  int        m_tail = 0;     // allocation pointer, 0..2*DEPTH-1
  bit        m_wen0, m_wen1;
  bit [3:0]  m_waddr0, m_waddr1;
  bit [15:0] m_wdata0, m_wdata1;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    bit        rdy, com0, com1;
    bit [15:0] claimed;
    m_ent_t    e;
    if (!rst_n || flush) begin
      mq.delete();
      m_tail = 0;
      m_wen0 = 0; m_wen1 = 0;
      m_waddr0 = 0; m_waddr1 = 0;
      m_wdata0 = 0; m_wdata1 = 0;
      return;
    end
    rdy  = (DEPTH - mq.size()) >= 2;
    com0 = (mq.size() > 0) && mq[0].done;
    com1 = com0 && (mq.size() > 1) && mq[1].done;
    m_wen0 = com0 && mq[0].wr;
    if (m_wen0) begin m_waddr0 = mq[0].dest; m_wdata0 = mq[0].data; end
    m_wen1 = com1 && mq[1].wr;
    if (m_wen1) begin m_waddr1 = mq[1].dest; m_wdata1 = mq[1].data; end
    // Completions: first port naming a tag claims it.
    claimed = '0;
    for (int p = 0; p < 3; p++) begin
      if (cv[p] && !claimed[ct[p]]) begin
        claimed[ct[p]] = 1'b1;
        foreach (mq[i]) begin
          if (mq[i].tag == int'(ct[p])) begin
            mq[i].done = 1;
            mq[i].data = cd[p];
          end
        end
      end
    end
    if (com0) void'(mq.pop_front());
    if (com1) void'(mq.pop_front());
    if (dv0 && rdy) begin
      e = '{tag: m_tail % DEPTH, wr: dwr0, dest: dd0, done: 0, data: 0};
      mq.push_back(e);
      m_tail = (m_tail + 1) % (2 * DEPTH);
      if (dv1) begin
        e = '{tag: m_tail % DEPTH, wr: dwr1, dest: dd1, done: 0, data: 0};
        mq.push_back(e);
        m_tail = (m_tail + 1) % (2 * DEPTH);
      end
    end
  endtask

  task automatic check_all();
    chk("count", 32'(count), 32'(mq.size()));
    chk("disp_ready", 32'(disp_ready), 32'((DEPTH - mq.size()) >= 2));
    chk("disp_tag0", 32'(disp_tag0), 32'(m_tail % DEPTH));
    chk("disp_tag1", 32'(disp_tag1), 32'((m_tail + 1) % DEPTH));
    chk("wen0", 32'(wen0), 32'(m_wen0));
    chk("waddr0", 32'(waddr0), 32'(m_waddr0));
    chk("wdata0", 32'(wdata0), 32'(m_wdata0));
    chk("wen1", 32'(wen1), 32'(m_wen1));
    chk("waddr1", 32'(waddr1), 32'(m_waddr1));
    chk("wdata1", 32'(wdata1), 32'(m_wdata1));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic idle();
    flush = 0; dv0 = 0; dv1 = 0; dwr0 = 0; dwr1 = 0; dd0 = 0; dd1 = 0;
    for (int p = 0; p < 3; p++) begin cv[p] = 0; ct[p] = 0; cd[p] = 0; end
  endtask

  task automatic disp(input bit w0, input int d0, input bit v1, input bit w1, input int d1);
    dv0 = 1; dwr0 = w0; dd0 = 4'(d0);
    dv1 = v1; dwr1 = w1; dd1 = 4'(d1);
  endtask

  task automatic cdb(input int p, input int tag, input int data);
    cv[p] = 1; ct[p] = 4'(tag); cd[p] = 16'(data);
  endtask

  task automatic do_flush();
    idle(); flush = 1; cycle(); idle();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    rst_n = 0;
    @(negedge clk);
    cycle(); cycle();
    chk("reset_count", 32'(count), 0);
    chk("reset_ready", 32'(disp_ready), 1);
    chk("reset_tag1", 32'(disp_tag1), 1);
    rst_n = 1;

    // Paired dispatch and commit.
    disp(1, 3, 1, 1, 5); cycle(); idle();
    cycle();
    cdb(0, 1, 'h00BB); cdb(1, 0, 'h00AA); cycle(); idle();
    cycle();
    chk("pair_wen0", 32'(wen0), 1);
    chk("pair_waddr0", 32'(waddr0), 3);
    chk("pair_wdata0", 32'(wdata0), 'h00AA);
    chk("pair_wen1", 32'(wen1), 1);
    chk("pair_waddr1", 32'(waddr1), 5);
    chk("pair_wdata1", 32'(wdata1), 'h00BB);
    chk("pair_count", 32'(count), 0);

    // In-order stall: younger done entry waits for the older one.
    do_flush();
    disp(1, 1, 1, 1, 2); cycle(); idle();
    cdb(0, 1, 'h1234); cycle(); idle();
    repeat (10) begin
      cycle();
      chk("stall_wen0", 32'(wen0), 0);
      chk("stall_wen1", 32'(wen1), 0);
    end
    cdb(2, 0, 'h4321); cycle(); idle();
    cycle();
    chk("stall_wdata0", 32'(wdata0), 'h4321);
    chk("stall_wdata1", 32'(wdata1), 'h1234);
    chk("stall_both", 32'({wen0, wen1}), 3);

    // Full and wrap.
    do_flush();
    for (int i = 0; i < 8; i++) begin disp(1, i, 1, 1, i + 8); cycle(); end
    idle();
    chk("full_count", 32'(count), 16);
    chk("full_ready", 32'(disp_ready), 0);
    disp(1, 1, 1, 1, 1); cycle(); idle();
    cdb(0, 0, 'hA000); cycle(); idle();
    cycle();
    chk("c15_count", 32'(count), 15);
    chk("c15_ready", 32'(disp_ready), 0);
    disp(1, 1, 1, 1, 1); cycle(); idle();
    cdb(1, 1, 'hA001); cycle(); idle();
    cycle();
    chk("wrap_tag0", 32'(disp_tag0), 0);
    chk("wrap_tag1", 32'(disp_tag1), 1);
    disp(1, 14, 1, 1, 15); cycle(); idle();
    for (int t = 1; t >= 0; t--) begin cdb(0, t, 'hB000 + t); cycle(); idle(); end
    for (int t = 15; t >= 2; t--) begin cdb(1, t, 'hC000 + t); cycle(); idle(); end
    repeat (12) cycle();
    chk("drain_count", 32'(count), 0);

    // No-write entry and CDB port conflict.
    do_flush();
    disp(0, 7, 1, 1, 9); cycle(); idle();
    cdb(0, 1, 'h1111); cdb(2, 1, 'h2222); cdb(1, 0, 'h5555); cycle(); idle();
    cycle();
    chk("nowr_wen0", 32'(wen0), 0);
    chk("conf_wen1", 32'(wen1), 1);
    chk("conf_waddr1", 32'(waddr1), 9);
    chk("conf_wdata1", 32'(wdata1), 'h1111);

    // Flush with entries live and a commit pending.
    do_flush();
    for (int i = 0; i < 3; i++) begin disp(1, i, 1, 1, i + 4); cycle(); end
    idle();
    cdb(0, 0, 'hD000); cdb(1, 1, 'hD001); cycle(); idle();
    chk("pre_flush_count", 32'(count), 6);
    flush = 1; cycle(); idle();
    chk("flush_wen0", 32'(wen0), 0);
    chk("flush_wen1", 32'(wen1), 0);
    chk("flush_count", 32'(count), 0);
    chk("flush_tag0", 32'(disp_tag0), 0);
    cdb(0, 2, 'hDEAD); cycle(); idle();
    cycle(); cycle();
    chk("stale_cdb_count", 32'(count), 0);
    chk("stale_cdb_wen0", 32'(wen0), 0);

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      idle();
      rst_n = ($urandom % 150) != 0;
      flush = ($urandom % 60) == 0;
      dv0 = ($urandom % 3) != 0;
      dv1 = ($urandom % 2) != 0;
      dwr0 = ($urandom % 4) != 0;
      dwr1 = ($urandom % 4) != 0;
      dd0 = 4'($urandom);
      dd1 = 4'($urandom);
      for (int p = 0; p < 3; p++) begin
        cv[p] = ($urandom % 2) != 0;
        if (mq.size() > 0 && ($urandom % 4) != 0)
          ct[p] = 4'(mq[$urandom_range(mq.size() - 1)].tag);
        else
          ct[p] = 4'($urandom);
        cd[p] = 16'($urandom);
      end
      cycle();
    end
    idle();
    rst_n = 1;
    repeat (4) cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rob_commit.md
Name: rob_commit

Overview:
- In-order reorder buffer and commit stage; sits directly upstream of the 16x16 architectural register file.
- Allocates up to 2 entries per cycle at dispatch and captures results from 3 CDB ports by tag.
- Retires up to 2 completed entries per cycle, in program order, by driving the register file's write ports 0 and 1.

Parameters:
DEPTH, 16, number of ROB entries (power of 2)
TAG_W, 4, log2(DEPTH); entry tag width
REG_W, 4, architectural register address width
DATA_W, 16, result data width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
flush  in  1  discard all entries (mispredict/exception)
disp_valid0  in  1  dispatch slot 0 request (older)
disp_wr0  in  1  slot 0 instruction writes a register
disp_dest0  in  REG_W  slot 0 destination register
disp_valid1  in  1  dispatch slot 1 request (younger)
disp_wr1  in  1  slot 1 writes a register
disp_dest1  in  REG_W  slot 1 destination register
disp_ready  out  1  at least 2 free entries
disp_tag0  out  TAG_W  tag allocated to slot 0
disp_tag1  out  TAG_W  tag allocated to slot 1
cdb_valid0..2  in  1 each  completion broadcast valid
cdb_tag0..2  in  TAG_W each  completing entry tag
cdb_data0..2  in  DATA_W each  result value
wen0  out  1  commit write enable, older retiring entry
waddr0  out  REG_W  commit register address, port 0
wdata0  out  DATA_W  commit data, port 0
wen1  out  1  commit write enable, younger retiring entry
waddr1  out  REG_W  commit register address, port 1
wdata1  out  DATA_W  commit data, port 1
count  out  TAG_W+1  occupied entries, 0..DEPTH

Behaviour:
- Storage:
  - head and tail pointers are TAG_W+1 bits, carrying a wrap bit.
  - Each entry holds valid, done, wr, dest and data.
  - Empty: head==tail. Full: count==DEPTH.
- Reset (rst_n=0 at clk edge):
  - head=tail=0, all valid/done cleared, count=0.
  - wen0=wen1=0; waddr0/1=0; wdata0/1=0.
- Dispatch:
  - disp_ready = (DEPTH - count) >= 2, from registered count only; same-cycle commits do not raise it.
  - disp_tag0 = tail[TAG_W-1:0] and disp_tag1 = tail+1; both combinational.
  - Slot 0 allocates iff disp_valid0 && disp_ready.
  - Slot 1 allocates iff disp_valid1 && disp_valid0 && disp_ready; disp_valid1 alone is ignored.
  - An allocated entry gets valid=1, done=0, wr and dest captured. tail advances by the number allocated, wrapping mod 2*DEPTH.
- Completion:
  - For each cdb_validN whose tag names a valid entry: done<=1, data<=cdb_dataN.
  - A CDB hit on an invalid entry is ignored.
  - Two ports with the same tag in one cycle: the lowest port index wins.
- Commit:
  - C0 = entry[head] valid && done.
  - C1 = C0 && entry[head+1] valid && done.
  - Committed entries are cleared; head advances by C0+C1.
  - Outputs are registered: wen0 <= C0 && wr, with waddr0/wdata0 from the head entry. Port 1 follows the same rule from head+1.
  - An entry with wr=0 retires with wen=0. waddr/wdata hold their last values when wen=0.
  - Both commits may target the same register. Port 1 carries the younger value and the register file gives port 1 priority.
- Latency:
  - A CDB hit in cycle N sets done at the end of N.
  - Commit is evaluated in N+1; wen is visible in cycle N+2.
  - A dispatch in cycle N cannot complete earlier than its CDB hit.
- Simultaneous events:
  - count_next = count + allocated - committed.
  - Dispatch, completion and commit all proceed in the same cycle.
  - Commit never passes an entry that is not done, so younger done entries wait.
- Flush:
  - Synchronous; priority over dispatch, completion and commit in that cycle.
  - Next state equals reset state: that cycle's would-be commits are dropped and wen0=wen1=0 the following cycle.
- Reset mid-operation: same as flush. Entries and pending CDB hits are lost.

Decomposition:
- Package rob_pkg:
  - DEPTH, TAG_W, REG_W, DATA_W constants.
  - rob_entry_t typedef {valid, done, wr, dest, data}.
  - ptr_t typedef (TAG_W+1 bits).
- One sub-module, rob_cdb_match:
  - Per-entry combinational match of the 3 CDB ports against the entry index, with port-0 priority.
  - Outputs hit and the selected data.
  - Instantiated DEPTH times.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles -> count=0, disp_ready=1, disp_tag0=0, disp_tag1=1, wen0=wen1=0.
- Paired dispatch and commit:
  - Stimulus: dispatch r3 (tag 0) and r5 (tag 1); cycle 3 CDB0 tag1=0x00BB, CDB1 tag0=0x00AA.
  - Response: in cycle 5 wen0=1 waddr0=3 wdata0=0x00AA and wen1=1 waddr1=5 wdata1=0x00BB; count returns to 0.
- In-order stall:
  - Stimulus: dispatch tags 0,1; complete tag 1 only.
  - Response: no wen for 10 cycles. Completing tag 0 gives both commits in the same cycle, older entry on port 0.
- Full and wrap:
  - Stimulus: dispatch 16 entries. Then complete and commit 2, dispatch 2.
  - Response: disp_ready=0 at count 15 and 16; disp_valid ignored while not ready; the new tags are 0 and 1 with the wrap bit set; commit order preserved.
- No-write and CDB conflict:
  - Stimulus: disp_wr0=0 entry; same-cycle CDB0 and CDB2 on one tag with 0x1111 and 0x2222.
  - Response: the entry retires with wen0=0; the conflicting tag commits 0x1111.
- Flush:
  - Stimulus: assert flush in the cycle C0 would commit, with 6 entries live.
  - Response: next cycle wen0=wen1=0, count=0, disp_tag0=0; a later CDB for an old tag has no effect.
